// File: rtl/ycc_pkg.sv
// Shared types for the 4:2:2 packer: sample width, packer state and pixel record.
package ycc_pkg;

    localparam int YCC_DATA_W = 16;

    typedef enum logic [1:0] {
        EVEN  = 2'd0,
        ODD   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic [YCC_DATA_W-1:0] y;
        logic [YCC_DATA_W-1:0] cb;
        logic [YCC_DATA_W-1:0] cr;
        logic                  eol;
    } pixel_t;

endpackage

// File: rtl/ycc_avg2.sv
// Combinational unsigned average of two chroma samples.
// Build option: YCC422_ROUND_EN selects round-half-up instead of truncation.
module ycc_avg2
    import ycc_pkg::*;
#(
    parameter int DATA_W = YCC_DATA_W
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_avg
);

    logic [DATA_W:0] w_sum;

    // One extra bit of headroom means the sum can never wrap, even with the rounding term.
`ifdef YCC422_ROUND_EN
    assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {{DATA_W{1'b0}}, 1'b1};
`else
    assign w_sum = {1'b0, i_a} + {1'b0, i_b};
`endif

    assign o_avg = DATA_W'(w_sum >> 1);

endmodule

// File: rtl/ycbcr_422_packer.sv
// Packs full-resolution Y/Cb/Cr pixels into 4:2:2 pairs with a single registered output slot.
// Build option: YCC422_ROUND_EN (rounded chroma average, see ycc_avg2).
module ycbcr_422_packer
    import ycc_pkg::*;
#(
    parameter int DATA_W = YCC_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_y,
    input  logic [DATA_W-1:0] in_cb,
    input  logic [DATA_W-1:0] in_cr,
    input  logic              in_eol,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_y0,
    output logic [DATA_W-1:0] out_y1,
    output logic [DATA_W-1:0] out_cb,
    output logic [DATA_W-1:0] out_cr,
    output logic              out_eol,
    output logic              out_single
);

    state_t            r_state;
    state_t            w_next_state;
    logic [DATA_W-1:0] r_hold_y;
    logic [DATA_W-1:0] r_hold_cb;
    logic [DATA_W-1:0] r_hold_cr;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_y0;
    logic [DATA_W-1:0] r_out_y1;
    logic [DATA_W-1:0] r_out_cb;
    logic [DATA_W-1:0] r_out_cr;
    logic              r_out_eol;
    logic              r_out_single;
    logic              w_slot_free;
    logic              w_accept;
    logic              w_load_pair;
    logic              w_load_flush;
    logic [DATA_W-1:0] w_avg_cb;
    logic [DATA_W-1:0] w_avg_cr;

    ycc_avg2 #(.DATA_W(DATA_W)) u_avg_cb (
        .i_a   (r_hold_cb),
        .i_b   (in_cb),
        .o_avg (w_avg_cb)
    );

    ycc_avg2 #(.DATA_W(DATA_W)) u_avg_cr (
        .i_a   (r_hold_cr),
        .i_b   (in_cr),
        .o_avg (w_avg_cr)
    );

    assign w_slot_free = !r_out_valid || out_ready;
    assign w_accept    = in_valid && in_ready;

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        w_load_pair  = 1'b0;
        w_load_flush = 1'b0;
        case (r_state)
            EVEN: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    w_next_state = in_eol ? FLUSH : ODD;
                end
            end
            ODD: begin
                in_ready = w_slot_free;
                if (w_accept) begin
                    w_load_pair  = 1'b1;
                    w_next_state = EVEN;
                end
            end
            FLUSH: begin
                if (w_slot_free) begin
                    w_load_flush = 1'b1;
                    w_next_state = EVEN;
                end
            end
            default: w_next_state = EVEN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= EVEN;
            r_hold_y  <= '0;
            r_hold_cb <= '0;
            r_hold_cr <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == EVEN && w_accept) begin
                r_hold_y  <= in_y;
                r_hold_cb <= in_cb;
                r_hold_cr <= in_cr;
            end
        end
    end

    // A reload wins over the emit-clear, so emit and reload in one cycle keeps the slot full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_y0     <= '0;
            r_out_y1     <= '0;
            r_out_cb     <= '0;
            r_out_cr     <= '0;
            r_out_eol    <= 1'b0;
            r_out_single <= 1'b0;
        end else if (w_load_pair) begin
            r_out_valid  <= 1'b1;
            r_out_y0     <= r_hold_y;
            r_out_y1     <= in_y;
            r_out_cb     <= w_avg_cb;
            r_out_cr     <= w_avg_cr;
            r_out_eol    <= in_eol;
            r_out_single <= 1'b0;
        end else if (w_load_flush) begin
            r_out_valid  <= 1'b1;
            r_out_y0     <= r_hold_y;
            r_out_y1     <= r_hold_y;
            r_out_cb     <= r_hold_cb;
            r_out_cr     <= r_hold_cr;
            r_out_eol    <= 1'b1;
            r_out_single <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_y0     = r_out_y0;
    assign out_y1     = r_out_y1;
    assign out_cb     = r_out_cb;
    assign out_cr     = r_out_cr;
    assign out_eol    = r_out_eol;
    assign out_single = r_out_single;

endmodule

// File: tb/tb_ycbcr_422_packer.sv
// Scoreboard bench for ycbcr_422_packer: directed vectors plus a throttled random stream.
// Expected chroma follows YCC422_ROUND_EN when the bundle is built with it.
module tb_ycbcr_422_packer;
    import ycc_pkg::*;

    localparam int W = YCC_DATA_W;

    typedef struct packed {
        logic [W-1:0] y0;
        logic [W-1:0] y1;
        logic [W-1:0] cb;
        logic [W-1:0] cr;
        logic         eol;
        logic         single;
    } pair_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_y;
    logic [W-1:0] in_cb;
    logic [W-1:0] in_cr;
    logic         in_eol;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_y0;
    logic [W-1:0] out_y1;
    logic [W-1:0] out_cb;
    logic [W-1:0] out_cr;
    logic         out_eol;
    logic         out_single;

    pair_t  expQ[$];
    pair_t  monAct;
    pair_t  monExp;
    int     checks    = 0;
    int     failures  = 0;
    int     readyMode = 0;
    bit     modelHas  = 0;
    pixel_t modelHold;

    ycbcr_422_packer #(.DATA_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_y       (in_y),
        .in_cb      (in_cb),
        .in_cr      (in_cr),
        .in_eol     (in_eol),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y0     (out_y0),
        .out_y1     (out_y1),
        .out_cb     (out_cb),
        .out_cr     (out_cr),
        .out_eol    (out_eol),
        .out_single (out_single)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream ready: 0 = always ready, 1 = random, 2 = stalled.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: every emitted pair is popped against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                monAct = '{out_y0, out_y1, out_cb, out_cr, out_eol, out_single};
                checks++;
                if (expQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_pair actual y0=%0h y1=%0h cb=%0h cr=%0h eol=%0b single=%0b, none expected",
                             monAct.y0, monAct.y1, monAct.cb, monAct.cr, monAct.eol, monAct.single);
                end else begin
                    monExp = expQ.pop_front();
                    if (monAct !== monExp) begin
                        failures++;
                        $display("[TB] FAIL pair actual y0=%0h y1=%0h cb=%0h cr=%0h eol=%0b single=%0b expected y0=%0h y1=%0h cb=%0h cr=%0h eol=%0b single=%0b",
                                 monAct.y0, monAct.y1, monAct.cb, monAct.cr, monAct.eol, monAct.single,
                                 monExp.y0, monExp.y1, monExp.cb, monExp.cr, monExp.eol, monExp.single);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] y, input logic [W-1:0] cb,
                                 input logic [W-1:0] cr, input logic eol);
        bit acc = 1'b0;
        int n   = 0;
        in_valid = 1'b1;
        in_y     = y;
        in_cb    = cb;
        in_cr    = cr;
        in_eol   = eol;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout actual=not accepted expected=accepted within 200 cycles");
        end
    endtask

    function automatic logic [W-1:0] avgRef(input logic [W-1:0] a, input logic [W-1:0] b);
        int s;
`ifdef YCC422_ROUND_EN
        s = int'(a) + int'(b) + 1;
`else
        s = int'(a) + int'(b);
`endif
        return W'(s >> 1);
    endfunction

    function automatic logic [W-1:0] pick(input logic [W-1:0] trunc, input logic [W-1:0] rnd);
`ifdef YCC422_ROUND_EN
        return rnd;
`else
        return trunc;
`endif
    endfunction

    // Reference packing for the random stream.
    task automatic modelPixel(input pixel_t p);
        if (!modelHas) begin
            if (p.eol) expQ.push_back('{p.y, p.y, p.cb, p.cr, 1'b1, 1'b1});
            else begin
                modelHold = p;
                modelHas  = 1'b1;
            end
        end else begin
            expQ.push_back('{modelHold.y, p.y, avgRef(modelHold.cb, p.cb),
                             avgRef(modelHold.cr, p.cr), p.eol, 1'b0});
            modelHas = 1'b0;
        end
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (expQ.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout actual=%0d pairs pending expected=0", expQ.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        pixel_t p;
        int     total;
        int     len;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_y     = '0;
        in_cb    = '0;
        in_cr    = '0;
        in_eol   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        @(negedge clk);
        checkOutput("reset_out_valid", W'(out_valid), 0);
        checkOutput("reset_in_ready", W'(in_ready), 1);
        checkOutput("reset_out_y0", out_y0, 0);
        checkOutput("reset_out_cb", out_cb, 0);
        checkOutput("reset_out_eol", W'(out_eol), 0);
        checkOutput("reset_out_single", W'(out_single), 0);

        $display("[TB] reset mid-pair");
        @(posedge clk);
        #1;
        readyMode = 2;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(1, 2, 3, 0);
        applyStimulus(4, 5, 6, 0);
        applyStimulus(9, 9, 9, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_out_valid", W'(out_valid), 0);
        checkOutput("rst_async_out_y0", out_y0, 0);
        expQ.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        readyMode = 0;

        $display("[TB] back-to-back pair");
        expQ.push_back('{16'd100, 16'd110, 16'd201, pick(16'd51, 16'd52), 1'b0, 1'b0});
        applyStimulus(100, 200, 50, 0);
        applyStimulus(110, 202, 53, 0);
        checkOutput("latency_out_valid", W'(out_valid), 1);
        checkOutput("latency_out_y1", out_y1, 110);
        drain(50);

        $display("[TB] odd-length line");
        expQ.push_back('{16'd20, 16'd30, 16'd45, pick(16'd65, 16'd66), 1'b0, 1'b0});
        expQ.push_back('{16'd7, 16'd7, 16'd9, 16'd11, 1'b1, 1'b1});
        applyStimulus(20, 40, 60, 0);
        applyStimulus(30, 50, 71, 0);
        applyStimulus(7, 9, 11, 1);
        drain(50);

        $display("[TB] backpressure in ODD");
        readyMode = 2;
        repeat (2) @(posedge clk);
        #1;
        expQ.push_back('{16'd10, 16'd12, 16'd21, pick(16'd31, 16'd32), 1'b0, 1'b0});
        expQ.push_back('{16'd14, 16'd16, 16'd25, pick(16'd37, 16'd38), 1'b1, 1'b0});
        applyStimulus(10, 20, 30, 0);
        applyStimulus(12, 22, 33, 0);
        applyStimulus(14, 24, 36, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_odd_in_ready", W'(in_ready), 0);
            checkOutput("stall_odd_out_valid", W'(out_valid), 1);
            checkOutput("stall_odd_out_y0", out_y0, 10);
            checkOutput("stall_odd_out_cr", out_cr, pick(16'd31, 16'd32));
        end
        readyMode = 0;
        applyStimulus(16, 26, 39, 1);
        drain(50);

        $display("[TB] backpressure in FLUSH");
        readyMode = 2;
        repeat (2) @(posedge clk);
        #1;
        expQ.push_back('{16'd1000, 16'd1002, 16'd3001, pick(16'd5001, 16'd5002), 1'b0, 1'b0});
        expQ.push_back('{16'd77, 16'd77, 16'd88, 16'd99, 1'b1, 1'b1});
        applyStimulus(1000, 3000, 5000, 0);
        applyStimulus(1002, 3002, 5003, 0);
        applyStimulus(77, 88, 99, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_flush_in_ready", W'(in_ready), 0);
            checkOutput("stall_flush_out_valid", W'(out_valid), 1);
            checkOutput("stall_flush_out_y1", out_y1, 1002);
        end
        readyMode = 0;
        drain(50);

        $display("[TB] max values");
        expQ.push_back('{16'h0010, 16'h0011, 16'hFFFF, pick(16'hFFFE, 16'hFFFF), 1'b0, 1'b0});
        applyStimulus(16'h0010, 16'hFFFF, 16'hFFFF, 0);
        applyStimulus(16'h0011, 16'hFFFF, 16'hFFFE, 0);
        drain(50);

        $display("[TB] random throttled stream");
        readyMode = 1;
        modelHas  = 1'b0;
        total     = 0;
        while (total < 1000) begin
            len = $urandom_range(1, 7);
            for (int k = 0; k < len; k++) begin
                p.y   = W'($urandom);
                p.cb  = W'($urandom);
                p.cr  = W'($urandom);
                p.eol = (k == len - 1);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                modelPixel(p);
                applyStimulus(p.y, p.cb, p.cr, p.eol);
                total++;
            end
        end
        readyMode = 0;
        drain(2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
